// File: rtl/averager_pkg.sv
// averager_pkg: shared state encoding, constants and saturating arithmetic for the averager sequencer
package averager_pkg;
  typedef enum logic [1:0] {RUN, ARMED, WRITE} state_t;
  localparam int MIN_COUNT_MAX = 3;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    return v == (64'd1 << w) - 64'd1 ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/averager_sequencer_if.sv
// averager_sequencer_if: control inputs and sequencing outputs of the averager sequencer
interface averager_sequencer_if #(
  parameter int FAST_COUNT_WIDTH = 13,
  parameter int SLOW_COUNT_WIDTH = 19,
  parameter int ADDR_WIDTH = 16
);
  logic clken, restart, avg_on;
  logic [FAST_COUNT_WIDTH-1:0] count_max;
  logic [SLOW_COUNT_WIDTH-1:0] n_avg_max, n_avg;
  logic ready, done, wen, overflow, clr_fback, avg_on_out, buf_sel;
  logic [ADDR_WIDTH-1:0] address;
  modport master(output clken, restart, avg_on, count_max, n_avg_max,
                 input ready, done, wen, n_avg, overflow, clr_fback, avg_on_out, buf_sel, address);
  modport slave(input clken, restart, avg_on, count_max, n_avg_max,
                output ready, done, wen, n_avg, overflow, clr_fback, avg_on_out, buf_sel, address);
endinterface

// File: rtl/averager_clken_pipe.sv
// averager_clken_pipe: delays the sample strobe to line it up with the datapath latency
module averager_clken_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0] pipe;
    always_ff @(posedge clk or negedge resetn)
      if (!resetn) pipe <= '0;
      else pipe <= DEPTH'({pipe, d});
    assign q = pipe[DEPTH-1];
  end
endmodule

// File: rtl/averager_sequencer.sv
// averager_sequencer: frame/address sequencer for the BRAM averager, with manual and fixed-N auto averaging
module averager_sequencer import averager_pkg::*; #(
  parameter int FAST_COUNT_WIDTH = 13,
  parameter int SLOW_COUNT_WIDTH = 19,
  parameter int CLKEN_DELAY = 2,
  parameter int ADDR_LSB = 2,
  parameter int PINGPONG = 1
) (
  input logic clk,
  input logic resetn,
  averager_sequencer_if.slave bus
);
  localparam int F = FAST_COUNT_WIDTH;
  localparam int S = SLOW_COUNT_WIDTH;
  localparam int AW = F + ADDR_LSB + PINGPONG;
  localparam logic [S:0] ONE = 1;
  state_t state;
  logic ce, fe, slow_full, auto_hit, restart_ok, overflow_int, r0, r1;
  logic [F-1:0] fast, cmr, cmr_next;
  logic [S-1:0] slow, slow_next;
  averager_clken_pipe #(.DEPTH(CLKEN_DELAY)) u_pipe (.clk(clk), .resetn(resetn), .d(bus.clken), .q(ce));
  assign fe = ce && fast == cmr;
  assign slow_next = S'(sat_inc(64'(slow), S));
  assign slow_full = &slow;
  assign auto_hit = bus.n_avg_max != '0 && {1'b0, slow} + ONE >= {1'b0, bus.n_avg_max} - ONE;
  assign restart_ok = bus.restart && ce && bus.n_avg_max == '0;
  assign cmr_next = bus.count_max < F'(MIN_COUNT_MAX) ? F'(MIN_COUNT_MAX) : bus.count_max;
  assign bus.wen = state == WRITE;
  always_comb begin
    bus.address = AW'(fast) << ADDR_LSB;
    if (PINGPONG != 0) bus.address[AW-1] = bus.buf_sel;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= RUN;
      fast <= '0;
      slow <= '0;
      cmr <= '1;
      overflow_int <= 1'b0;
      r0 <= 1'b0;
      r1 <= 1'b0;
      bus.ready <= 1'b1;
      bus.done <= 1'b0;
      bus.n_avg <= '0;
      bus.overflow <= 1'b0;
      bus.clr_fback <= 1'b1;
      bus.avg_on_out <= 1'b0;
      bus.buf_sel <= 1'b0;
    end else begin
      bus.done <= state == WRITE && fe;
      if (ce) fast <= fe ? '0 : fast + 1'b1;
      // feedback control settles two samples before the write frame closes
      if (state == WRITE && ce && fast == cmr - F'(2)) begin
        bus.clr_fback <= ~bus.avg_on;
        r0 <= bus.avg_on;
        r1 <= r0;
      end
      case (state)
        RUN: begin
          if (fe) begin
            slow <= slow_next;
            if (slow_full) overflow_int <= 1'b1;
          end
          if (restart_ok) begin
            state <= fe ? WRITE : ARMED;
            bus.ready <= 1'b0;
          end else if (fe && auto_hit) state <= WRITE;
        end
        ARMED: if (fe) begin
          state <= WRITE;
          slow <= slow_next;
          if (slow_full) overflow_int <= 1'b1;
        end
        WRITE: if (fe) begin
          state <= bus.n_avg_max == S'(1) ? WRITE : RUN;
          slow <= '0;
          bus.n_avg <= slow_next;
          bus.overflow <= overflow_int;
          overflow_int <= 1'b0;
          bus.buf_sel <= PINGPONG != 0 && !bus.buf_sel;
          cmr <= cmr_next;
          bus.ready <= 1'b1;
          bus.avg_on_out <= r1;
        end
        default: state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_averager_sequencer.sv
// tb_averager_sequencer: frame-level reference model compared every cycle, plus directed literal checks
module tb_averager_sequencer;
  localparam int SMAX = (1 << 19) - 1;
  logic clk = 1'b0, resetn = 1'b0, resetn_b = 1'b0;
  logic [31:0] pat = 32'hB3A5_6C1D;
  int checks = 0, passes = 0, len;
  bit cmp_en = 1'b0;
  always #5 clk = ~clk;

  averager_sequencer_if #(.FAST_COUNT_WIDTH(13), .SLOW_COUNT_WIDTH(19), .ADDR_WIDTH(16)) ia();
  averager_sequencer_if #(.FAST_COUNT_WIDTH(3), .SLOW_COUNT_WIDTH(3), .ADDR_WIDTH(6)) ib();
  averager_sequencer dut (.clk(clk), .resetn(resetn), .bus(ia.slave));
  averager_sequencer #(.FAST_COUNT_WIDTH(3), .SLOW_COUNT_WIDTH(3)) dut_b (.clk(clk), .resetn(resetn_b), .bus(ib.slave));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // model: sample position within a frame, frames counted per average, write-frame flag
  int m_pos, m_cmr, m_frames, m_navg;
  bit m_armed, m_write, m_ready, m_done, m_ovf_int, m_ovf, m_clr, m_r0, m_r1, m_aout, m_bsel;
  bit [1:0] hist;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pos = 0; m_cmr = 8191; m_frames = 0; m_navg = 0;
      m_armed = 0; m_write = 0; m_ready = 1; m_done = 0; m_ovf_int = 0; m_ovf = 0;
      m_clr = 1; m_r0 = 0; m_r1 = 0; m_aout = 0; m_bsel = 0; hist = 0;
    end else begin : step
      bit ce, fe, manual;
      ce = hist[1];
      hist = {hist[0], ia.clken};
      manual = ia.n_avg_max == 0;
      fe = ce && m_pos == m_cmr;
      m_done = 0;
      if (ce && m_write && m_pos == m_cmr - 2) begin
        m_r1 = m_r0; m_r0 = ia.avg_on; m_clr = !ia.avg_on;
      end
      if (fe && m_write) begin
        m_navg = m_frames + 1 > SMAX ? SMAX : m_frames + 1;
        m_ovf = m_ovf_int; m_ovf_int = 0; m_frames = 0;
        m_bsel = !m_bsel; m_ready = 1; m_done = 1; m_aout = m_r1;
        m_cmr = ia.count_max < 3 ? 3 : int'(ia.count_max);
        m_write = ia.n_avg_max == 1;
      end else if (fe) begin
        if (m_frames == SMAX) m_ovf_int = 1; else m_frames++;
        if (m_armed) begin m_armed = 0; m_write = 1; end
        else if (manual && ia.restart) begin m_write = 1; m_ready = 0; end
        else if (!manual && m_frames >= int'(ia.n_avg_max) - 1) m_write = 1;
      end else if (ce && manual && ia.restart && !m_armed && !m_write) begin
        m_armed = 1; m_ready = 0;
      end
      if (ce) m_pos = fe ? 0 : m_pos + 1;
    end
  end

  always @(negedge clk) if (cmp_en && resetn) begin
    chk("ready", ia.ready, m_ready);
    chk("done", ia.done, m_done);
    chk("wen", ia.wen, m_write);
    chk("n_avg", ia.n_avg, m_navg);
    chk("overflow", ia.overflow, m_ovf);
    chk("clr_fback", ia.clr_fback, m_clr);
    chk("avg_on_out", ia.avg_on_out, m_aout);
    chk("buf_sel", ia.buf_sel, m_bsel);
    chk("address", ia.address, (longint'(m_bsel) << 15) | (longint'(m_pos) << 2));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart_a();
    ia.restart = 1'b1; tick(1); ia.restart = 1'b0;
  endtask

  task automatic restart_b();
    ib.restart = 1'b1; tick(1); ib.restart = 1'b0;
  endtask

  task automatic wait_done(input bit b, input int budget, input string name);
    int k = 0;
    do begin tick(1); k++; end while (!(b ? ib.done : ia.done) && k < budget);
    chk(name, b ? ib.done : ia.done, 1);
  endtask

  task automatic frame_len(output int n);
    int g = 0;
    while (ia.address[14:2] != 0 && g < 100) begin tick(1); g++; end
    n = 0;
    do begin tick(1); n++; end while (ia.address[14:2] != 0 && n < 100);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, " ready"}, ia.ready, 1);
    chk({tag, " wen"}, ia.wen, 0);
    chk({tag, " done"}, ia.done, 0);
    chk({tag, " n_avg"}, ia.n_avg, 0);
    chk({tag, " overflow"}, ia.overflow, 0);
    chk({tag, " clr_fback"}, ia.clr_fback, 1);
    chk({tag, " avg_on_out"}, ia.avg_on_out, 0);
    chk({tag, " buf_sel"}, ia.buf_sel, 0);
    chk({tag, " address"}, ia.address, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    ia.clken = 0; ia.restart = 0; ia.count_max = 7; ia.n_avg_max = 0; ia.avg_on = 1;
    ib.clken = 1; ib.restart = 0; ib.count_max = 7; ib.n_avg_max = 0; ib.avg_on = 1;
    tick(3);
    rst_chk("reset");
    resetn = 1; cmp_en = 1; ia.clken = 1;
    // the frame length register starts at all-ones, so one write is needed to load count_max
    tick(5);
    restart_a();
    wait_done(0, 20000, "warmup done");
    chk("warmup n_avg", ia.n_avg, 2);
    chk("warmup buf_sel", ia.buf_sel, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t1 address", ia.address, 32768 + 4 * i);
      tick(1);
    end
    tick(64 + 3);
    chk("t1 ready", ia.ready, 1);
    chk("t1 wen", ia.wen, 0);
    restart_a();
    chk("t2 ready low", ia.ready, 0);
    wait_done(0, 100, "t2 done");
    chk("t2 n_avg", ia.n_avg, 11);
    chk("t2 ready", ia.ready, 1);
    chk("t2 buf_sel", ia.buf_sel, 0);
    ia.n_avg_max = 4; ia.avg_on = 0;
    for (int w = 0; w < 3; w++) begin
      wait_done(0, 100, "t3 done");
      chk("t3 n_avg", ia.n_avg, 4);
      chk("t3 buf_sel", ia.buf_sel, w % 2 == 0);
      chk("t3 ready", ia.ready, 1);
    end
    ia.n_avg_max = 0; ia.avg_on = 1;
    tick(3);
    ia.count_max = 15;
    frame_len(len);
    chk("t4 len before reload", len, 8);
    restart_a();
    wait_done(0, 100, "t4 done 15");
    frame_len(len);
    chk("t4 len 16", len, 16);
    ia.count_max = 1;
    restart_a();
    wait_done(0, 100, "t4 done 1");
    frame_len(len);
    chk("t4 len min", len, 4);
    for (int i = 0; i < 64; i++) begin
      ia.clken = pat[i % 32];
      ia.restart = i == 20;
      tick(1);
    end
    ia.restart = 0; ia.clken = 1;
    tick(40);
    restart_a();
    begin
      int k = 0;
      while (!ia.wen && k < 50) begin tick(1); k++; end
    end
    chk("t6 wen before reset", ia.wen, 1);
    tick(1);
    @(posedge clk);
    #3 resetn = 0;
    #1 rst_chk("async reset");
    repeat (3) begin
      @(negedge clk);
      chk("t6 no done in reset", ia.done, 0);
    end
    resetn = 1;
    tick(20);
    chk("t6 ready after", ia.ready, 1);
    resetn_b = 1;
    tick(2 + 80 + 3);
    restart_b();
    wait_done(1, 100, "t5 done sat");
    chk("t5 n_avg sat", ib.n_avg, 7);
    chk("t5 overflow", ib.overflow, 1);
    tick(8 + 3);
    restart_b();
    wait_done(1, 100, "t5 done 3");
    chk("t5 n_avg 3", ib.n_avg, 3);
    chk("t5 overflow cleared", ib.overflow, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
